// File: rtl/pipe_pkg.sv
// Shared widths, control-vector field offsets and ID/EX payload layout for the
// MIPS pipeline stage registers.
package pipe_pkg;

  localparam int IFID_CTRL_W  = 16;
  localparam int IFID_DATA_W  = 64;   // pc + instruction word
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_CTRL_W = 16;
  localparam int EXMEM_DATA_W = 69;   // alu result + store data + dest reg
  localparam int MEMWB_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 69;   // alu result + load data + dest reg

  localparam int REGWRITE_BIT = 0;
  localparam int MEMWRITE_LSB = 1;
  localparam int MEMWRITE_W   = 4;
  localparam int ALUCTRL_LSB  = 5;
  localparam int ALUCTRL_W    = 4;
  localparam int EOP_BIT      = 15;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } idex_payload_t;

  localparam int IDEX_DATA_W = $bits(idex_payload_t);

  function automatic logic [1:0] occ_count(input logic head_v, input logic skid_v);
    return {1'b0, head_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage entry of a pipeline stage: valid, control and payload with
// clear / load / drop, updated on the falling clock edge.
module pipe_skid_slot #(
  parameter int CTRL_W   = 16,
  parameter int DATA_W   = 116,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLR_DATA) data_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      // Payload is left in place; only the entry's meaning is withdrawn.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(negedge clk_i) begin
    valid_q <= valid_d;
    ctrl_q  <= ctrl_d;
    data_q  <= data_d;
  end

  assign valid_o = valid_q;
  assign ctrl_o  = valid_q ? ctrl_q : '0;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic MIPS pipeline stage register with valid/ready, flush, debug step and
// bubble (NOP) insertion. Define PIPE_STAGE_SKID_EN for the 2-entry skid variant.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = IDEX_CTRL_W,
  parameter int DATA_W   = IDEX_DATA_W,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_dbg,
  input  logic              step_en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              rst, clr, in_fire, out_fire;
  logic              hd_v, hd_load, hd_drop;
  logic [CTRL_W-1:0] hd_ctrl, hd_ctrl_in;
  logic [DATA_W-1:0] hd_data, hd_data_in;

  assign rst      = reset | reset_dbg;
  assign clr      = rst | (flush & step_en);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = hd_v & out_ready & step_en & ~clr;

`ifdef PIPE_STAGE_SKID_EN
  logic              sk_v, sk_load, sk_drop;
  logic [CTRL_W-1:0] sk_ctrl;
  logic [DATA_W-1:0] sk_data;

  // Readiness depends only on the skid register, never on out_ready.
  assign in_ready   = step_en & ~flush & ~rst & ~sk_v;
  assign hd_load    = (~hd_v & in_fire) | (out_fire & (sk_v | in_fire));
  assign hd_drop    = out_fire & ~sk_v & ~in_fire;
  assign hd_ctrl_in = sk_v ? sk_ctrl : in_ctrl;
  assign hd_data_in = sk_v ? sk_data : in_data;
  assign sk_load    = in_fire & hd_v & ~out_fire;
  assign sk_drop    = out_fire & sk_v;
  assign occupancy  = occ_count(hd_v, sk_v);

  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_skid (
    .clk_i   (clk),
    .clr_i   (clr),
    .load_i  (sk_load),
    .drop_i  (sk_drop),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (sk_v),
    .ctrl_o  (sk_ctrl),
    .data_o  (sk_data)
  );
`else
  assign in_ready   = step_en & ~flush & ~rst & (~hd_v | out_ready);
  assign hd_load    = in_fire;
  assign hd_drop    = out_fire & ~in_fire;
  assign hd_ctrl_in = in_ctrl;
  assign hd_data_in = in_data;
  assign occupancy  = occ_count(hd_v, 1'b0);
`endif

  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_head (
    .clk_i   (clk),
    .clr_i   (clr),
    .load_i  (hd_load),
    .drop_i  (hd_drop),
    .ctrl_i  (hd_ctrl_in),
    .data_i  (hd_data_in),
    .valid_o (hd_v),
    .ctrl_o  (hd_ctrl),
    .data_o  (hd_data)
  );

  assign out_valid = hd_v;
  assign out_ctrl  = hd_ctrl;
  assign out_data  = hd_data;

endmodule
